// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and decode helpers shared by the ALU and its adder.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
//
// Contents:
//   alu_op_t        3-bit ALUOp type
//   ALU_*           MIPS-style ALUOp codes
//   op_uses_sub()   1 when the shared adder must run in subtract mode
//   op_flags_ovf()  1 when the op reports signed overflow
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 3'b000;
    localparam alu_op_t ALU_OR   = 3'b001;
    localparam alu_op_t ALU_ADD  = 3'b010;
    localparam alu_op_t ALU_XOR  = 3'b011;
    localparam alu_op_t ALU_NOR  = 3'b100;
    localparam alu_op_t ALU_SLTU = 3'b101;
    localparam alu_op_t ALU_SUB  = 3'b110;
    localparam alu_op_t ALU_SLT  = 3'b111;

    // SUB and both set-less-than ops all need A - B from the one adder.
    function automatic logic op_uses_sub(input alu_op_t op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

    // Only true arithmetic results carry an overflow flag; comparisons use
    // the subtractor internally but must report Overflow = 0.
    function automatic logic op_flags_ovf(input alu_op_t op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_if.sv
// alu_if: operand/opcode bundle into the ALU and result/flag bundle out of it.
// Latency: none (wires only).
// Backpressure: none; the ALU is always ready and samples inputs continuously.
//
// Signals:
//   A, B, ALUOp                      driven by the master (producer of operands)
//   Result, Zero, Overflow           combinational results, driven by the ALU
//   Result_q, Zero_q, Ovf_q          registered copies, driven by the ALU
interface alu_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    alu_op_t          ALUOp;

    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;

    logic [WIDTH-1:0] Result_q;
    logic             Zero_q;
    logic             Ovf_q;

    modport master (
        output A, B, ALUOp,
        input  Result, Zero, Overflow,
        input  Result_q, Zero_q, Ovf_q
    );

    modport slave (
        input  A, B, ALUOp,
        output Result, Zero, Overflow,
        output Result_q, Zero_q, Ovf_q
    );

endinterface : alu_if

// File: rtl/alu_addsub.sv
// alu_addsub: single shared adder computing a + (sub ? ~b : b) + sub.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   a_i, b_i      operands (two's complement)
//   sub_i         1 = subtract (a - b), 0 = add (a + b)
//   sum_o         wrapped result, modulo 2^WIDTH
//   carry_out_o   carry out of the MSB; in subtract mode 0 means a < b unsigned
//   ovf_o         signed overflow of the operation actually performed
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    // Subtraction as a + ~b + 1 keeps one carry chain for every arithmetic op.
    assign b_eff   = sub_i ? ~b_i : b_i;
    assign sum_ext = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};

    assign sum_o       = sum_ext[WIDTH-1:0];
    assign carry_out_o = sum_ext[WIDTH];

    // Overflow is judged against the effective addend: adding two same-signed
    // values that yield the opposite sign. With b inverted this is exactly the
    // subtract rule (signs of a and b differ, result sign differs from a).
    assign ovf_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule : alu_addsub

// File: rtl/alu.sv
// alu: single-cycle 32-bit integer ALU (MIPS-style ALUOp) with registered result/flags.
// Latency: Result/Zero/Overflow combinational (0 cycles); *_q copies 1 cycle.
// Backpressure: none; always ready, inputs sampled every cycle.
//
// Ports:
//   clk   rising-edge clock for the registered outputs
//   rst   synchronous active-high reset; clears only the registered outputs
//   bus   alu_if slave: A, B, ALUOp in; Result, Zero, Overflow, Result_q, Zero_q, Ovf_q out
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    alu_if.slave   bus
);

    // ------------------------------------------------------------------
    // Shared adder/subtractor
    // ------------------------------------------------------------------
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             ovf_addsub;

    assign sub = op_uses_sub(bus.ALUOp);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i         (bus.A),
        .b_i         (bus.B),
        .sub_i       (sub),
        .sum_o       (sum),
        .carry_out_o (carry_out),
        .ovf_o       (ovf_addsub)
    );

    // Signed less-than: the diff sign alone is wrong when the subtraction
    // overflows (e.g. 0x80000000 - 1), so correct it with the overflow bit.
    logic slt_less;
    logic sltu_less;

    assign slt_less  = sum[WIDTH-1] ^ ovf_addsub;
    // a + ~b + 1 produces no carry exactly when a < b unsigned.
    assign sltu_less = ~carry_out;

    // ------------------------------------------------------------------
    // Op mux, flags
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             ovf_d;

    always_comb begin
        result_d = '0;
        unique case (bus.ALUOp)
            ALU_AND:  result_d = bus.A & bus.B;
            ALU_OR:   result_d = bus.A | bus.B;
            ALU_ADD:  result_d = sum;
            ALU_XOR:  result_d = bus.A ^ bus.B;
            ALU_NOR:  result_d = ~(bus.A | bus.B);
            ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, sltu_less};
            ALU_SUB:  result_d = sum;
            ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_less};
            default:  result_d = '0;
        endcase
    end

    assign zero_d = (result_d == '0);
    assign ovf_d  = op_flags_ovf(bus.ALUOp) & ovf_addsub;

    assign bus.Result   = result_d;
    assign bus.Zero     = zero_d;
    assign bus.Overflow = ovf_d;

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    // Reset takes priority over the capture at the same edge. Zero_q clears
    // to 0 even though Result_q = 0, marking "no valid result yet".
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.Result_q = result_q;
    assign bus.Zero_q   = zero_q;
    assign bus.Ovf_q    = ovf_q;

endmodule : alu

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an arithmetic reference model.
// Latency: checks combinational outputs 1 ns after driving, registered outputs 1 ns after the next edge.
// Backpressure: not applicable.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    alu_if #(.WIDTH(W)) bus ();

    alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on wide signed values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         output logic [W-1:0] r, output logic z, output logic v);
        longint sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v  = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                wide = sa + sb;
                r    = W'(wide);
                v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'd3: r = a ^ b;
            3'd4: r = ~(a | b);
            3'd5: r = (a < b) ? 32'd1 : 32'd0;
            3'd6: begin
                wide = sa - sb;
                r    = W'(wide);
                v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        z = (r == 0);
    endtask

    // Drive, check combinational outputs, then check the registered copy.
    task automatic dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic [W-1:0] er, input logic ez,
                       input logic ev);
        bus.A = a; bus.B = b; bus.ALUOp = op;
        #1;
        chk({tag, ".Result"},   bus.Result,         er);
        chk({tag, ".Zero"},     W'(bus.Zero),       W'(ez));
        chk({tag, ".Overflow"}, W'(bus.Overflow),   W'(ev));
        @(posedge clk); #1;
        chk({tag, ".Result_q"}, bus.Result_q,       er);
        chk({tag, ".Zero_q"},   W'(bus.Zero_q),     W'(ez));
        chk({tag, ".Ovf_q"},    W'(bus.Ovf_q),      W'(ev));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [W-1:0] a, b, er;
        logic [2:0]   op;
        logic         ez, ev;

        // Reset held for two edges with live inputs: registers stay clear,
        // combinational path keeps working.
        rst = 1'b1;
        bus.A = 32'd1; bus.B = 32'd2; bus.ALUOp = ALU_ADD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst.Result_q", bus.Result_q,     32'd0);
        chk("rst.Zero_q",   W'(bus.Zero_q),   32'd0);
        chk("rst.Ovf_q",    W'(bus.Ovf_q),    32'd0);
        chk("rst.Result",   bus.Result,       32'd3);
        rst = 1'b0;

        dir("add",      32'd1,          32'd2,          ALU_ADD,  32'd3,          1'b0, 1'b0);
        dir("sub",      32'd3,          32'd4,          ALU_SUB,  32'hFFFF_FFFF,  1'b0, 1'b0);
        dir("and",      32'd12,         32'd10,         ALU_AND,  32'd8,          1'b0, 1'b0);
        dir("or",       32'd12,         32'd10,         ALU_OR,   32'd14,         1'b0, 1'b0);
        dir("xor",      32'hF0F0_F0F0,  32'h0FF0_0FF0,  ALU_XOR,  32'hFF00_FF00,  1'b0, 1'b0);
        dir("nor0",     32'd0,          32'd0,          ALU_NOR,  32'hFFFF_FFFF,  1'b0, 1'b0);
        dir("nor1",     32'hFFFF_FFFF,  32'd0,          ALU_NOR,  32'd0,          1'b1, 1'b0);
        dir("slt_neg",  32'hFFFF_FFFB,  32'd5,          ALU_SLT,  32'd1,          1'b0, 1'b0);
        dir("slt_f",    32'd10,         32'hFFFF_FFFE,  ALU_SLT,  32'd0,          1'b1, 1'b0);
        dir("slt_min",  32'h8000_0000,  32'd1,          ALU_SLT,  32'd1,          1'b0, 1'b0);
        dir("sltu_f",   32'hFFFF_FFFF,  32'd1,          ALU_SLTU, 32'd0,          1'b1, 1'b0);
        dir("sltu_t",   32'd1,          32'hFFFF_FFFF,  ALU_SLTU, 32'd1,          1'b0, 1'b0);
        dir("add_ovf",  32'h7FFF_FFFF,  32'd1,          ALU_ADD,  32'h8000_0000,  1'b0, 1'b1);
        dir("sub_ovf",  32'h8000_0000,  32'd1,          ALU_SUB,  32'h7FFF_FFFF,  1'b0, 1'b1);
        dir("add_wrap", 32'hFFFF_FFFF,  32'd1,          ALU_ADD,  32'd0,          1'b1, 1'b0);

        // Mid-stream reset: wins over capture, then capture resumes.
        dir("pre_rst",  32'd7,          32'd5,          ALU_ADD,  32'd12,         1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst1.Result_q", bus.Result_q, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst2.Result_q", bus.Result_q,   32'd0);
        chk("mid_rst2.Zero_q",   W'(bus.Zero_q), 32'd0);
        chk("mid_rst2.Ovf_q",    W'(bus.Ovf_q),  32'd0);
        chk("mid_rst2.Result",   bus.Result,     32'd12);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.Result_q", bus.Result_q, 32'd12);

        // Randomized operands and opcodes against the reference model.
        for (int i = 0; i < 300; i++) begin
            a  = pick();
            b  = pick();
            op = 3'($urandom_range(0, 7));
            model(a, b, op, er, ez, ev);
            dir($sformatf("rnd%0d_op%0d", i, op), a, b, op, er, ez, ev);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu
